data_sync_mc: RTL

Multi-channel, parametrised successor to the single-bus data synchronizer. It sits in the destination clock domain of the UART and receives `NUM_CH` independent source-domain buses, each qualified by its own enable. Each enable passes through an N-stage synchronizer and an edge detector, and the qualified bus is captured into a per-channel holding register. Captured words are merged round-robin onto one valid/ready output stream, with per-channel sticky overrun reporting.

---
 rtl/data_sync_mc.sv | 119 +++++++++++
 1 files changed

// File: rtl/data_sync_mc.sv
// Multi-channel enable synchronizer: each channel's enable is synchronized and edge-detected,
// its bus slice is captured, and captured words are merged round-robin onto one valid/ready stream.
module data_sync_mc #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = 0,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    output logic [BUS_WIDTH-1:0]        sync_bus,
    output logic [CH_W-1:0]             sync_ch,
    output logic                        sync_valid,
    input  logic                        sync_ready,
    output logic [NUM_CH-1:0]           overrun,
    input  logic                        overrun_clr
);

    localparam int MSB = NUM_STAGES - 1;
    localparam int SW  = CH_W + 1;

    logic [NUM_STAGES-1:0] sreg [NUM_CH];
    logic [BUS_WIDTH-1:0]  hold [NUM_CH];
    logic [NUM_CH-1:0]     edge_flop;
    logic [NUM_CH-1:0]     evt;
    logic [NUM_CH-1:0]     pend;
    logic [NUM_CH-1:0]     pend_next;
    logic [NUM_CH-1:0]     grant_oh;
    logic [NUM_CH-1:0]     ovr_set;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       rr_next;
    logic [CH_W-1:0]       grant_ch;
    logic [CH_W-1:0]       idx_c;
    logic [SW-1:0]         sum;
    logic                  grant_vld;
    logic                  out_free;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        evt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (TOGGLE_MODE != 0) evt[c] = sreg[c][MSB] ^ edge_flop[c];
            else                  evt[c] = sreg[c][MSB] & ~edge_flop[c];
        end
    end

    assign out_free = ~sync_valid | sync_ready;

    // Walk candidates from farthest to nearest so the first pending channel at/after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        grant_oh  = '0;
        sum       = '0;
        idx_c     = '0;
        if (out_free) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                sum = {1'b0, rr_ptr} + SW'(i);
                if (sum >= SW'(NUM_CH)) sum = sum - SW'(NUM_CH);
                idx_c = sum[CH_W-1:0];
                if (pend[idx_c]) begin
                    grant_vld     = 1'b1;
                    grant_ch      = idx_c;
                    grant_oh      = '0;
                    grant_oh[idx_c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_next = '0;
        if (int'(grant_ch) != NUM_CH - 1) rr_next = grant_ch + CH_W'(1);
    end

    // A channel granted this cycle keeps pend only if new data arrived alongside; that is not an overrun.
    assign pend_next = (pend & ~grant_oh) | evt;
    assign ovr_set   = evt & pend & ~grant_oh;

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the holding registers are reset too, so a reset leaves no stale word behind.
            for (int c = 0; c < NUM_CH; c++) begin
                sreg[c] <= '0;
                hold[c] <= '0;
            end
            edge_flop  <= '0;
            pend       <= '0;
            rr_ptr     <= '0;
            sync_bus   <= '0;
            sync_ch    <= '0;
            sync_valid <= 1'b0;
            overrun    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (NUM_STAGES > 1) sreg[c] <= {sreg[c][NUM_STAGES-2:0], bus_enable[c]};
                else                sreg[c] <= bus_enable[c];
                edge_flop[c] <= sreg[c][MSB];
                if (evt[c]) hold[c] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
            end
            pend    <= pend_next;
            overrun <= (overrun & {NUM_CH{~overrun_clr}}) | ovr_set;
            if (out_free) begin
                if (grant_vld) begin
                    sync_bus   <= hold[grant_ch];
                    sync_ch    <= grant_ch;
                    sync_valid <= 1'b1;
                    rr_ptr     <= rr_next;
                end else begin
                    sync_valid <= 1'b0;
                end
            end
        end
    end

endmodule
